// File: rtl/inst_fetch_pkg.sv
// ============================================================================
// Module : inst_fetch_pkg
// Brief  : Shared types and constants for the instruction fetch unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package inst_fetch_pkg;

    localparam int          OPCODE_W = 6;
    localparam int          INST_W   = 32;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_ERR  = 2'd3
    } fetch_state_e;

    // Signed word offset turned into a byte offset.
    function automatic logic [31:0] word_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetch_next_pc.sv
// ============================================================================
// Module : inst_fetch_next_pc
// Brief  : Combinational next-PC select (sequential / branch / optional jump).
//          Jump inputs exist only when IFETCH_JUMP_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_fetch_next_pc
    import inst_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch,
    input  logic [15:0] imm,
`ifdef IFETCH_JUMP_EN
    input  logic        jump,
    input  logic [25:0] jump_target,
`endif
    output logic [31:0] pc_next
);

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;

    always_comb begin
        pc_plus4      = pc + PC_STEP;
        branch_target = pc_plus4 + word_offset(imm);
        pc_next       = branch ? branch_target : pc_plus4;
`ifdef IFETCH_JUMP_EN
        // Jump overrides a simultaneous branch.
        if (jump) begin
            pc_next = {pc_plus4[31:28], jump_target, 2'b00};
        end
`endif
    end

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
// Module : inst_fetch
// Brief  : Single-outstanding instruction fetch FSM with imem timeout.
//          Optional jump support enabled by defining IFETCH_JUMP_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_ready,
    input  logic [INST_W-1:0]   imem_rdata,
    output logic                inst_valid,
    output logic [INST_W-1:0]   inst,
    output logic [OPCODE_W-1:0] opcode,
    output logic [31:0]         pc_out,
    input  logic                inst_ack,
    input  logic                branch_taken,
    input  logic [15:0]         branch_imm,
`ifdef IFETCH_JUMP_EN
    input  logic                jump,
    input  logic [25:0]         jump_target,
`endif
    output logic                fetch_err
);

    localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] PC_INIT   = {RESET_PC[31:2], 2'b00};

    fetch_state_e       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [INST_W-1:0]  inst_q, inst_d;
    logic [31:0]        pc_out_q, pc_out_d;
    logic               inst_valid_q, inst_valid_d;
    logic               imem_req_q, imem_req_d;
    logic               fetch_err_q, fetch_err_d;
    logic [7:0]         wait_cnt_q, wait_cnt_d;
    logic [31:0]        pc_next;

    inst_fetch_next_pc u_next_pc (
        .pc          (pc_q),
        .branch      (branch_taken),
        .imm         (branch_imm),
`ifdef IFETCH_JUMP_EN
        .jump        (jump),
        .jump_target (jump_target),
`endif
        .pc_next     (pc_next)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        pc_out_d     = pc_out_q;
        inst_valid_d = inst_valid_q;
        imem_req_d   = imem_req_q;
        fetch_err_d  = fetch_err_q;
        wait_cnt_d   = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                state_d    = ST_REQ;
                imem_req_d = 1'b1;
                wait_cnt_d = '0;
            end
            ST_REQ: begin
                if (imem_ready) begin
                    inst_d       = imem_rdata;
                    pc_out_d     = pc_q;
                    inst_valid_d = 1'b1;
                    imem_req_d   = 1'b0;
                    state_d      = ST_HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    // Ready on the last allowed cycle wins; otherwise give up.
                    if (wait_cnt_q == WAIT_LAST) begin
                        imem_req_d  = 1'b0;
                        fetch_err_d = 1'b1;
                        state_d     = ST_ERR;
                    end
                end
            end
            ST_HOLD: begin
                if (inst_ack) begin
                    pc_d         = pc_next;
                    inst_valid_d = 1'b0;
                    imem_req_d   = 1'b1;
                    wait_cnt_d   = '0;
                    state_d      = ST_REQ;
                end
            end
            ST_ERR: begin
                imem_req_d   = 1'b0;
                inst_valid_d = 1'b0;
                fetch_err_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= PC_INIT;
            inst_q       <= '0;
            pc_out_q     <= '0;
            inst_valid_q <= 1'b0;
            imem_req_q   <= 1'b0;
            fetch_err_q  <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            pc_out_q     <= pc_out_d;
            inst_valid_q <= inst_valid_d;
            imem_req_q   <= imem_req_d;
            fetch_err_q  <= fetch_err_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign opcode     = inst_q[INST_W-1 -: OPCODE_W];
    assign pc_out     = pc_out_q;
    assign fetch_err  = fetch_err_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// Module : tb_inst_fetch
// Brief  : Scoreboard testbench for inst_fetch (IFETCH_JUMP_EN optional).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch;

`ifdef IFETCH_JUMP_EN
    localparam logic [31:0] RESET_PC = 32'h3000_0000;
`else
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`endif
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [5:0]  opcode;
    logic [31:0] pc_out;
    logic        inst_ack;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        fetch_err;
`ifdef IFETCH_JUMP_EN
    logic        jump;
    logic [25:0] jump_target;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    inst_fetch #(
        .RESET_PC (RESET_PC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .opcode       (opcode),
        .pc_out       (pc_out),
        .inst_ack     (inst_ack),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
`ifdef IFETCH_JUMP_EN
        .jump         (jump),
        .jump_target  (jump_target),
`endif
        .fetch_err    (fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'hA5A5_0000) + {a[15:0], 16'h1357};
    endfunction

    task automatic idle_inputs();
        imem_ready   = 1'b0;
        imem_rdata   = '0;
        inst_ack     = 1'b0;
        branch_taken = 1'b0;
        branch_imm   = '0;
`ifdef IFETCH_JUMP_EN
        jump         = 1'b0;
        jump_target  = '0;
`endif
    endtask

    // Ends on the first negedge where the DUT sits in its first request cycle.
    task automatic do_reset();
        idle_inputs();
        sb_q.delete();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic serve(input logic [31:0] addr, input logic [31:0] data);
        imem_ready = 1'b1;
        imem_rdata = data;
        sb_q.push_back('{pc: addr, data: data});
    endtask

    task automatic advance(input int n);
        for (int k = 0; k < n; k++) begin
            imem_ready = 1'b1;
            imem_rdata = 32'h1357_0000 + 32'(k);
            @(negedge clk);
            imem_ready = 1'b0;
            inst_ack   = 1'b1;
            @(negedge clk);
            inst_ack   = 1'b0;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || fetch_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: req=%b valid=%b err=%b required 0/0/0", imem_req, inst_valid, fetch_err);
        end
        checks++;
        if (inst !== 32'h0 || pc_out !== 32'h0 || opcode !== 6'h0) begin
            failures++;
            $display("FAIL reset_regs: inst=%h pc_out=%h opcode=%h required zeros", inst, pc_out, opcode);
        end
        checks++;
        if (imem_addr !== RESET_PC) begin
            failures++;
            $display("FAIL reset_addr: addr=%h required %h", imem_addr, RESET_PC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_req: req=%b addr=%h valid=%b required 1/%h/0", imem_req, imem_addr, inst_valid, RESET_PC);
        end
    endtask

    task automatic test_stream();
        logic [31:0] ep;
        exp_t        e;
        do_reset();
        ep = RESET_PC;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== ep) begin
                failures++;
                $display("FAIL stream_req[%0d]: req=%b addr=%h required 1/%h", i, imem_req, imem_addr, ep);
            end
            serve(ep, mem_word(ep));
            @(negedge clk);
            imem_ready = 1'b0;
            e = sb_q.pop_front();
            checks++;
            if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin
                failures++;
                $display("FAIL stream_valid[%0d]: valid=%b req=%b required 1/0", i, inst_valid, imem_req);
            end
            checks++;
            if (inst !== e.data || pc_out !== e.pc || opcode !== e.data[31:26]) begin
                failures++;
                $display("FAIL stream_data[%0d]: inst=%h pc_out=%h opcode=%h required %h/%h/%h",
                         i, inst, pc_out, opcode, e.data, e.pc, e.data[31:26]);
            end
            inst_ack = 1'b1;
            ep       = ep + 32'd4;
            @(negedge clk);
            inst_ack = 1'b0;
        end
    endtask

    task automatic test_hold_stable();
        exp_t e;
        do_reset();
        advance(4);
        checks++;
        if (imem_addr !== RESET_PC + 32'h10) begin
            failures++;
            $display("FAIL hold_addr: addr=%h required %h", imem_addr, RESET_PC + 32'h10);
        end
        serve(RESET_PC + 32'h10, 32'h8C01_0004);
        @(negedge clk);
        e = sb_q.pop_front();
        // Ready/data wiggling while holding must not disturb the instruction.
        imem_rdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (inst_valid !== 1'b1 || inst !== e.data || opcode !== 6'h23 ||
                pc_out !== e.pc || imem_req !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable[%0d]: valid=%b inst=%h opcode=%h pc_out=%h req=%b required 1/%h/23/%h/0",
                         c, inst_valid, inst, opcode, pc_out, imem_req, e.data, e.pc);
            end
            imem_ready = (c % 2 == 0);
            @(negedge clk);
        end
        imem_ready = 1'b0;
        inst_ack   = 1'b1;
        @(negedge clk);
        inst_ack   = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC + 32'h14 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_next: req=%b addr=%h valid=%b required 1/%h/0", imem_req, imem_addr, inst_valid, RESET_PC + 32'h14);
        end
    endtask

    task automatic test_branch();
        exp_t e;
        do_reset();
        advance(8);
        // Ack and branch while requesting must be ignored.
        inst_ack     = 1'b1;
        branch_taken = 1'b1;
        branch_imm   = 16'h0100;
        @(negedge clk);
        @(negedge clk);
        idle_inputs();
        checks++;
        if (imem_addr !== RESET_PC + 32'h20 || imem_req !== 1'b1 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL branch_ignored: addr=%h req=%b valid=%b required %h/1/0", imem_addr, imem_req, inst_valid, RESET_PC + 32'h20);
        end
        serve(RESET_PC + 32'h20, mem_word(RESET_PC + 32'h20));
        @(negedge clk);
        imem_ready = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (pc_out !== e.pc || inst !== e.data) begin
            failures++;
            $display("FAIL branch_fetch: pc_out=%h inst=%h required %h/%h", pc_out, inst, e.pc, e.data);
        end
        inst_ack = 1'b1; branch_taken = 1'b1; branch_imm = 16'hFFFE;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (imem_addr !== RESET_PC + 32'h1C || imem_req !== 1'b1) begin
            failures++;
            $display("FAIL branch_back: addr=%h req=%b required %h/1", imem_addr, imem_req, RESET_PC + 32'h1C);
        end
        serve(RESET_PC + 32'h1C, mem_word(RESET_PC + 32'h1C));
        @(negedge clk);
        imem_ready = 1'b0;
        void'(sb_q.pop_front());
        inst_ack = 1'b1; branch_taken = 1'b1; branch_imm = 16'h0010;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (imem_addr !== RESET_PC + 32'h60) begin
            failures++;
            $display("FAIL branch_fwd: addr=%h required %h", imem_addr, RESET_PC + 32'h60);
        end
        serve(RESET_PC + 32'h60, mem_word(RESET_PC + 32'h60));
        @(negedge clk);
        imem_ready = 1'b0;
        void'(sb_q.pop_front());
        inst_ack = 1'b1; branch_taken = 1'b1; branch_imm = 16'hFFE6;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (imem_addr !== RESET_PC - 32'd4) begin
            failures++;
            $display("FAIL branch_top: addr=%h required %h", imem_addr, RESET_PC - 32'd4);
        end
        serve(RESET_PC - 32'd4, 32'h0BAD_F00D);
        @(negedge clk);
        imem_ready = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (pc_out !== e.pc || inst !== e.data) begin
            failures++;
            $display("FAIL branch_top_data: pc_out=%h inst=%h required %h/%h", pc_out, inst, e.pc, e.data);
        end
        inst_ack = 1'b1;
        @(negedge clk);
        inst_ack = 1'b0;
        checks++;
        if (imem_addr !== RESET_PC) begin
            failures++;
            $display("FAIL pc_wrap: addr=%h required %h", imem_addr, RESET_PC);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        do_reset();
        repeat (TIMEOUT - 1) @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_wait: req=%b err=%b required 1/0", imem_req, fetch_err);
        end
        serve(RESET_PC, 32'h2222_3333);
        @(negedge clk);
        imem_ready = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (inst_valid !== 1'b1 || fetch_err !== 1'b0 || inst !== e.data || pc_out !== e.pc) begin
            failures++;
            $display("FAIL timeout_last_ready: valid=%b err=%b inst=%h pc_out=%h required 1/0/%h/%h",
                     inst_valid, fetch_err, inst, pc_out, e.data, e.pc);
        end
        inst_ack = 1'b1;
        @(negedge clk);
        inst_ack = 1'b0;
        repeat (TIMEOUT - 1) @(negedge clk);
        checks++;
        if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin
            failures++;
            $display("FAIL timeout_early: err=%b req=%b required 0/1", fetch_err, imem_req);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_err: err=%b req=%b valid=%b required 1/0/0", fetch_err, imem_req, inst_valid);
        end
        imem_ready = 1'b1;
        inst_ack   = 1'b1;
        repeat (3) @(negedge clk);
        idle_inputs();
        checks++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_sticky: err=%b req=%b valid=%b required 1/0/0", fetch_err, imem_req, inst_valid);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_reset();
        advance(16);
        checks++;
        if (imem_addr !== RESET_PC + 32'h40 || inst === 32'h0) begin
            failures++;
            $display("FAIL midrst_setup: addr=%h inst=%h required %h/nonzero", imem_addr, inst, RESET_PC + 32'h40);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || pc_out !== 32'h0 ||
            fetch_err !== 1'b0 || imem_addr !== RESET_PC) begin
            failures++;
            $display("FAIL midrst_async: req=%b valid=%b inst=%h pc_out=%h err=%b addr=%h required 0/0/0/0/0/%h",
                     imem_req, inst_valid, inst, pc_out, fetch_err, imem_addr, RESET_PC);
        end
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            failures++;
            $display("FAIL midrst_refetch: req=%b addr=%h required 1/%h", imem_req, imem_addr, RESET_PC);
        end
        serve(RESET_PC, 32'h4444_5555);
        @(negedge clk);
        imem_ready = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (inst_valid !== 1'b1 || pc_out !== e.pc || inst !== e.data) begin
            failures++;
            $display("FAIL midrst_data: valid=%b pc_out=%h inst=%h required 1/%h/%h", inst_valid, pc_out, inst, e.pc, e.data);
        end
    endtask

`ifdef IFETCH_JUMP_EN
    task automatic test_jump();
        do_reset();
        serve(RESET_PC, mem_word(RESET_PC));
        @(negedge clk);
        imem_ready = 1'b0;
        void'(sb_q.pop_front());
        inst_ack = 1'b1; jump = 1'b1; jump_target = 26'h10;
        branch_taken = 1'b1; branch_imm = 16'hFFFE;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (imem_addr !== 32'h3000_0040 || imem_req !== 1'b1) begin
            failures++;
            $display("FAIL jump_target: addr=%h req=%b required 30000040/1", imem_addr, imem_req);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_hold_stable();
        test_branch();
        test_timeout();
        test_reset_mid();
`ifdef IFETCH_JUMP_EN
        test_jump();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
